// File: rtl/fifo_rd_packer_if.sv
// FIFO pop port and packed-word output stream of the read-side packer.
// The master side is the packer itself; the slave side is the FIFO plus consumer.
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
);
  localparam int OUT_WIDTH = DATA_WIDTH * PACK;
  localparam int CW        = $clog2(PACK + 1);

  logic                  empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ren;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic [CW-1:0]         out_bytes;
  logic                  flush_done;

  modport master (
    input  empty, data_out, flush, out_ready,
    output ren, out_valid, out_data, out_bytes, flush_done
  );

  modport slave (
    output empty, data_out, flush, out_ready,
    input  ren, out_valid, out_data, out_bytes, flush_done
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-domain drain stage: pops FIFO entries and packs PACK of them little-endian
// into one wide word on a valid/ready stream; flush emits a short tail with its lane count.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic             rclk,
  input  logic             r_rstn,
  fifo_rd_packer_if.master bus
);
  localparam int OUT_WIDTH = DATA_WIDTH * PACK;
  localparam int CW        = $clog2(PACK + 1);
  localparam int IW        = $clog2(PACK);
  localparam logic [CW-1:0] CNT_LAST = CW'(PACK - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(PACK);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                          state_q, state_d;
  logic [PACK-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            pend_q, pend_d;
  logic [OUT_WIDTH-1:0]            out_data_q, out_data_d;
  logic [CW-1:0]                   out_bytes_q, out_bytes_d;
  logic                            out_valid_q, out_valid_d;
  logic                            flush_done_q, flush_done_d;

  logic                            slot_free;
  logic                            room;
  logic                            ren;
  logic [IW-1:0]                   lane;
  logic [PACK-1:0][DATA_WIDTH-1:0] partial;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign lane      = cnt_q[IW-1:0];

  // A pop while the last lane is still in flight is safe only if that lane is
  // certain to transfer out; an idle output register guarantees it without
  // looking at out_ready.
  assign room = ((cnt_q + CW'(pend_q)) < CNT_FULL) ||
                (pend_q && (cnt_q == CNT_LAST) && !out_valid_q);

  assign ren = r_rstn && (state_q == ST_RUN) && !bus.flush && !bus.empty && room;

  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    assign partial[gi] = (CW'(gi) < cnt_q) ? acc_q[gi] : '0;
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    pend_d       = ren;
    out_data_d   = out_data_q;
    out_bytes_d  = out_bytes_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    flush_done_d = 1'b0;

    if (pend_q) begin
      if (cnt_q < CNT_LAST) begin
        acc_d[lane] = bus.data_out;
        cnt_d       = cnt_q + CW'(1);
      end else if (slot_free) begin
        out_data_d  = {bus.data_out, acc_q[PACK-2:0]};
        out_bytes_d = CNT_FULL;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end else begin
        acc_d[PACK-1] = bus.data_out;
        cnt_d         = CNT_FULL;
      end
    end else if ((cnt_q == CNT_FULL) && slot_free) begin
      out_data_d  = acc_q;
      out_bytes_d = CNT_FULL;
      out_valid_d = 1'b1;
      cnt_d       = '0;
    end

    case (state_q)
      ST_RUN: begin
        if (bus.flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!pend_q && (cnt_q != CNT_FULL) && slot_free) begin
          if (cnt_q != '0) begin
            out_data_d  = partial;
            out_bytes_d = cnt_q;
            out_valid_d = 1'b1;
            cnt_d       = '0;
          end
          flush_done_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!r_rstn) begin
      state_q      <= ST_RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      out_data_q   <= '0;
      out_bytes_q  <= '0;
      out_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      out_data_q   <= out_data_d;
      out_bytes_q  <= out_bytes_d;
      out_valid_q  <= out_valid_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.ren        = ren;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_bytes  = out_bytes_q;
  assign bus.flush_done = flush_done_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue-based FIFO and byte-packing model
// predict words and flush_done pulses; a monitor checks every handshake.
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int PK = 4;
  localparam int OW = DW * PK;
  localparam int CW = $clog2(PK + 1);

  logic rclk = 1'b0;
  logic r_rstn;

  fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) bus ();

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .rclk  (rclk),
    .r_rstn(r_rstn),
    .bus   (bus)
  );

  always #5 rclk = ~rclk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] to_push[$];
  logic [DW-1:0] partial_q[$];
  logic [OW-1:0] exp_data[$];
  int            exp_bytes[$];
  int            exp_fd = 0;

  function automatic void emit_partial();
    logic [OW-1:0] w;
    w = '0;
    for (int i = 0; i < partial_q.size(); i++) w[i*DW +: DW] = partial_q[i];
    exp_data.push_back(w);
    exp_bytes.push_back(partial_q.size());
    partial_q.delete();
  endfunction

  // FIFO model plus reference: every popped byte joins the open word in order;
  // a full word or a flush closes it; reset drops everything not yet accepted.
  initial begin
    logic [DW-1:0] b;
    bus.empty = 1'b1;
    forever begin
      @(posedge rclk);
      if (!r_rstn) begin
        partial_q.delete();
        exp_data.delete();
        exp_bytes.delete();
        exp_fd = 0;
      end else begin
        if (bus.ren) begin
          total++;
          if (fifo_q.size() == 0) begin
            bad++;
            $display("FAIL ren_while_empty: got ren=1 with empty FIFO, required ren=0");
          end else begin
            b = fifo_q.pop_front();
            bus.data_out <= b;
            partial_q.push_back(b);
            if (partial_q.size() == PK) emit_partial();
          end
        end else begin
          bus.data_out <= DW'($urandom);
        end
        if (bus.flush) begin
          if (partial_q.size() > 0) emit_partial();
          exp_fd++;
        end
      end
      while (to_push.size() > 0) fifo_q.push_back(to_push.pop_front());
      bus.empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: compares each accepted word and flush_done pulse with the scoreboard.
  initial begin
    logic          hold_v;
    logic [OW-1:0] hold_d;
    logic [CW-1:0] hold_b;
    logic [OW-1:0] ed;
    int            eb;
    hold_v = 1'b0;
    hold_d = '0;
    hold_b = '0;
    forever begin
      @(negedge rclk);
      #1;
      if (!r_rstn) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          total++;
          if (!bus.out_valid || bus.out_data !== hold_d || bus.out_bytes !== hold_b) begin
            bad++;
            $display("FAIL hold_stable: got v=%0b data=%h bytes=%0d, required v=1 data=%h bytes=%0d",
                     bus.out_valid, bus.out_data, bus.out_bytes, hold_d, hold_b);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          total++;
          if (exp_data.size() == 0) begin
            bad++;
            $display("FAIL unexpected_word: got data=%h bytes=%0d, required no word",
                     bus.out_data, bus.out_bytes);
          end else begin
            ed = exp_data.pop_front();
            eb = exp_bytes.pop_front();
            if (bus.out_data !== ed || int'(bus.out_bytes) != eb) begin
              bad++;
              $display("FAIL word: got data=%h bytes=%0d, required data=%h bytes=%0d",
                       bus.out_data, bus.out_bytes, ed, eb);
            end else begin
              $display("word data=%h bytes=%0d", bus.out_data, bus.out_bytes);
            end
          end
        end
        hold_v = bus.out_valid && !bus.out_ready;
        hold_d = bus.out_data;
        hold_b = bus.out_bytes;
        if (bus.flush_done) begin
          total++;
          if (exp_fd == 0) begin
            bad++;
            $display("FAIL flush_done_extra: got pulse, required none");
          end else begin
            exp_fd--;
            $display("flush_done seen");
          end
        end
      end
    end
  end

  task automatic push(input logic [DW-1:0] b);
    to_push.push_back(b);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end else begin
      $display("check %s = %0h", name, got);
    end
  endtask

  // Single-cycle flush; returns the number of cycles until flush_done was seen.
  task automatic pulse_flush(input bit rnd, output int n);
    @(negedge rclk);
    bus.flush = 1'b1;
    #1 check("ren_masked_by_flush", bus.ren, 0);
    @(negedge rclk);
    bus.flush = 1'b0;
    for (n = 0; n < 60; n++) begin
      #1;
      if (bus.flush_done) break;
      check("ren_low_in_flush", bus.ren, 0);
      @(negedge rclk);
      if (rnd) bus.out_ready = ($urandom_range(0, 1) != 0);
      else     bus.out_ready = 1'b1;
    end
    if (n >= 60) check("flush_timeout", 1, 0);
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || to_push.size() != 0 || exp_data.size() != 0 || bus.out_valid)
           && n < maxc) begin
      @(negedge rclk);
      n++;
    end
    check("drain_pending_words", exp_data.size(), 0);
    repeat (2) @(negedge rclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int run, best, pops, nfl, seen;
    r_rstn        = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held three cycles with data waiting in the FIFO.
    for (int i = 0; i < 8; i++) push(DW'(8'h11 + i));
    repeat (3) begin
      @(negedge rclk);
      #1;
      check("reset_ren", bus.ren, 0);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_out_bytes", bus.out_bytes, 0);
    end
    r_rstn = 1'b1;
    #1 check("post_reset_out_valid", bus.out_valid, 0);

    // Streaming: eight back-to-back pops, two full words.
    run  = 0;
    best = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.ren) begin
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      @(negedge rclk);
      #1;
    end
    check("stream_ren_run", best, 8);
    drain(50);

    // Backpressure: consumer stalled, popping must stop after two words' worth.
    @(negedge rclk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(DW'(8'h21 + i));
    pops = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk);
      #1;
      if (bus.ren) pops++;
    end
    check("bp_pop_count", pops, 8);
    check("bp_ren_low", bus.ren, 0);
    check("bp_out_valid_held", bus.out_valid, 1);
    @(negedge rclk);
    bus.out_ready = 1'b1;
    drain(50);

    // Partial flush of three bytes while another byte waits in the FIFO.
    @(negedge rclk);
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (6) @(negedge rclk);
    push(8'hB1);
    pulse_flush(1'b0, nfl);
    check("partial_flush_latency", nfl, 1);
    pulse_flush(1'b0, nfl);
    check("single_byte_flush_done", (nfl <= 2), 1);
    drain(50);

    // Flush with nothing accumulated.
    pulse_flush(1'b0, nfl);
    check("empty_flush_latency", nfl, 1);
    check("empty_flush_no_word", bus.out_valid, 0);
    drain(20);

    // Reset while the second byte of a word is in flight.
    @(negedge rclk);
    push(8'hE1); push(8'hE2);
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge rclk);
      #1;
      if (bus.ren) seen++;
    end
    check("midword_pops", seen, 2);
    @(negedge rclk);
    r_rstn = 1'b0;
    repeat (2) @(negedge rclk);
    r_rstn = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'(8'h01 + i));
    drain(50);

    // Randomized traffic with stalls, flushes and occasional resets.
    for (int it = 0; it < 500; it++) begin
      @(negedge rclk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) push(DW'($urandom));
      end
      if ($urandom_range(0, 39) == 0) pulse_flush(1'b1, nfl);
      if ($urandom_range(0, 249) == 0) begin
        r_rstn = 1'b0;
        @(negedge rclk);
        r_rstn = 1'b1;
      end
    end

    @(negedge rclk);
    bus.out_ready = 1'b1;
    drain(200);
    pulse_flush(1'b0, nfl);
    drain(50);
    check("leftover_words", exp_data.size(), 0);
    check("leftover_flush_done", exp_fd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
